// File: rtl/sirv_d_beat_gatherer.sv
// rtl/sirv_d_beat_gatherer.sv - gathers single-byte D beats into one full-width D response
// Header fields come from the first beat; errors are OR-accumulated over the message.
module sirv_d_beat_gatherer #(
   parameter int OUT_BYTES = 4,
   parameter int SRC_W     = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   output logic                   enq_ready,
   input  logic                   enq_valid,
   input  logic [2:0]             enq_bits_opcode,
   input  logic [1:0]             enq_bits_param,
   input  logic [2:0]             enq_bits_size,
   input  logic [SRC_W-1:0]       enq_bits_source,
   input  logic                   enq_bits_error,
   input  logic [7:0]             enq_bits_data,
   input  logic                   deq_ready,
   output logic                   deq_valid,
   output logic [2:0]             deq_bits_opcode,
   output logic [1:0]             deq_bits_param,
   output logic [2:0]             deq_bits_size,
   output logic [SRC_W-1:0]       deq_bits_source,
   output logic                   deq_bits_error,
   output logic [8*OUT_BYTES-1:0] deq_bits_data,
   output logic                   busy,
   output logic                   full
);

   localparam int LG = $clog2(OUT_BYTES);

   typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

   state_t                 state_q;
   logic [LG-1:0]          cnt_q;
   logic [2:0]             opcode_q;
   logic [1:0]             param_q;
   logic [2:0]             size_q;
   logic [SRC_W-1:0]       source_q;
   logic                   error_q;
   logic [8*OUT_BYTES-1:0] data_q;
   logic [8*OUT_BYTES-1:0] data_d;
   logic                   error_d;

   logic          enq_fire;
   logic          deq_fire;
   logic          first_beat;
   logic [2:0]    cur_size;
   logic [LG-1:0] last_idx;
   logic          last_beat;

   assign full       = (state_q == FULL);
   assign deq_valid  = full;
   assign busy       = (cnt_q != '0);
   assign enq_ready  = ~full | deq_ready;
   assign enq_fire   = enq_valid & enq_ready;
   assign deq_fire   = deq_valid & deq_ready;
   assign first_beat = (cnt_q == '0);

   // The size of an in-flight message lives in size_q; only the first beat uses the live field.
   assign cur_size  = first_beat ? enq_bits_size : size_q;
   assign last_beat = (cnt_q == last_idx);

   always_comb begin
      last_idx = '1;
      if (cur_size < 3'(LG))
         last_idx = LG'((32'd1 << cur_size) - 32'd1);
   end

   always_comb begin
      data_d  = data_q;
      error_d = error_q;
      if (enq_fire) begin
         if (first_beat) begin
            data_d  = '0;
            error_d = enq_bits_error;
         end else begin
            error_d = error_q | enq_bits_error;
         end
         data_d[{cnt_q, 3'b000} +: 8] = enq_bits_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= COLLECT;
         cnt_q    <= '0;
         opcode_q <= '0;
         param_q  <= '0;
         size_q   <= '0;
         source_q <= '0;
         error_q  <= 1'b0;
         data_q   <= '0;
      end else begin
         data_q  <= data_d;
         error_q <= error_d;
         if (deq_fire && !enq_fire)
            state_q <= COLLECT;
         if (enq_fire) begin
            if (first_beat) begin
               opcode_q <= enq_bits_opcode;
               param_q  <= enq_bits_param;
               size_q   <= enq_bits_size;
               source_q <= enq_bits_source;
            end
            if (last_beat) begin
               cnt_q   <= '0;
               state_q <= FULL;
            end else begin
               cnt_q   <= cnt_q + LG'(1);
               state_q <= COLLECT;
            end
         end
      end
   end

   assign deq_bits_opcode = opcode_q;
   assign deq_bits_param  = param_q;
   assign deq_bits_size   = size_q;
   assign deq_bits_source = source_q;
   assign deq_bits_error  = error_q;
   assign deq_bits_data   = data_q;

endmodule

// File: tb/tb_sirv_d_beat_gatherer.sv
// tb/tb_sirv_d_beat_gatherer.sv - directed self-checking bench for sirv_d_beat_gatherer
module tb_sirv_d_beat_gatherer;

   logic        clock;
   logic        reset;
   logic        enq_ready;
   logic        enq_valid;
   logic [2:0]  enq_bits_opcode;
   logic [1:0]  enq_bits_param;
   logic [2:0]  enq_bits_size;
   logic [1:0]  enq_bits_source;
   logic        enq_bits_error;
   logic [7:0]  enq_bits_data;
   logic        deq_ready;
   logic        deq_valid;
   logic [2:0]  deq_bits_opcode;
   logic [1:0]  deq_bits_param;
   logic [2:0]  deq_bits_size;
   logic [1:0]  deq_bits_source;
   logic        deq_bits_error;
   logic [31:0] deq_bits_data;
   logic        busy;
   logic        full;

   int checks;
   int failures;

   sirv_d_beat_gatherer #(.OUT_BYTES(4), .SRC_W(2)) dut (
      .clock           (clock),
      .reset           (reset),
      .enq_ready       (enq_ready),
      .enq_valid       (enq_valid),
      .enq_bits_opcode (enq_bits_opcode),
      .enq_bits_param  (enq_bits_param),
      .enq_bits_size   (enq_bits_size),
      .enq_bits_source (enq_bits_source),
      .enq_bits_error  (enq_bits_error),
      .enq_bits_data   (enq_bits_data),
      .deq_ready       (deq_ready),
      .deq_valid       (deq_valid),
      .deq_bits_opcode (deq_bits_opcode),
      .deq_bits_param  (deq_bits_param),
      .deq_bits_size   (deq_bits_size),
      .deq_bits_source (deq_bits_source),
      .deq_bits_error  (deq_bits_error),
      .deq_bits_data   (deq_bits_data),
      .busy            (busy),
      .full            (full)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [2:0] size, input logic [1:0] src, input logic err, input logic [7:0] data);
      enq_valid       = 1'b1;
      enq_bits_opcode = 3'd1;
      enq_bits_param  = 2'd0;
      enq_bits_size   = size;
      enq_bits_source = src;
      enq_bits_error  = err;
      enq_bits_data   = data;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      enq_valid = 1'b0;
      enq_bits_opcode = '0;
      enq_bits_param = '0;
      enq_bits_size = '0;
      enq_bits_source = '0;
      enq_bits_error = 1'b0;
      enq_bits_data = '0;
      deq_ready = 1'b0;
      tick();
      tick();
      chk("rst_deq_valid", deq_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_full", full, 0);
      chk("rst_data", deq_bits_data, 0);
      chk("rst_enq_ready", enq_ready, 1);
      reset = 1'b0;
      tick();

      // single-beat message
      drive(3'd0, 2'd1, 1'b0, 8'hA5);
      tick();
      enq_valid = 1'b0;
      chk("t1_valid", deq_valid, 1);
      chk("t1_data", deq_bits_data, 32'h0000_00A5);
      chk("t1_source", deq_bits_source, 1);
      chk("t1_size", deq_bits_size, 0);
      chk("t1_error", deq_bits_error, 0);
      chk("t1_opcode", deq_bits_opcode, 1);
      deq_ready = 1'b1;
      tick();
      chk("t1_drained", deq_valid, 0);

      // four beats, valid held high
      drive(3'd2, 2'd2, 1'b0, 8'h11);
      tick();
      chk("t2_busy", busy, 1);
      chk("t2_ready1", enq_ready, 1);
      chk("t2_novalid", deq_valid, 0);
      enq_bits_data = 8'h22;
      enq_bits_size = 3'd0;
      tick();
      chk("t2_ready2", enq_ready, 1);
      enq_bits_data = 8'h33;
      tick();
      enq_bits_data = 8'h44;
      tick();
      enq_valid = 1'b0;
      chk("t2_valid", deq_valid, 1);
      chk("t2_data", deq_bits_data, 32'h4433_2211);
      chk("t2_size", deq_bits_size, 2);
      chk("t2_busy_done", busy, 0);
      tick();
      chk("t2_drained", deq_valid, 0);

      // two beats, error on second, held under backpressure
      deq_ready = 1'b0;
      drive(3'd1, 2'd3, 1'b0, 8'hBE);
      tick();
      drive(3'd1, 2'd3, 1'b1, 8'hEF);
      tick();
      drive(3'd0, 2'd0, 1'b0, 8'h99);
      chk("t3_valid", deq_valid, 1);
      chk("t3_enq_ready", enq_ready, 0);
      for (int i = 0; i < 5; i++) tick();
      chk("t3_hold_data", deq_bits_data, 32'h0000_EFBE);
      chk("t3_hold_error", deq_bits_error, 1);
      chk("t3_hold_valid", deq_valid, 1);
      chk("t3_hold_ready", enq_ready, 0);
      enq_valid = 1'b0;
      deq_ready = 1'b1;
      #1;
      chk("t3_ready_rise", enq_ready, 1);
      tick();
      chk("t3_drained", deq_valid, 0);

      // back-to-back single-beat messages
      deq_ready = 1'b0;
      drive(3'd0, 2'd1, 1'b0, 8'h3C);
      tick();
      chk("t4_a_data", deq_bits_data, 32'h0000_003C);
      drive(3'd0, 2'd2, 1'b0, 8'h5A);
      deq_ready = 1'b1;
      #1;
      chk("t4_enq_ready", enq_ready, 1);
      tick();
      enq_valid = 1'b0;
      chk("t4_b_valid", deq_valid, 1);
      chk("t4_b_data", deq_bits_data, 32'h0000_005A);
      chk("t4_b_source", deq_bits_source, 2);
      // FULL while the first beat of a two-beat message arrives
      drive(3'd1, 2'd0, 1'b0, 8'h01);
      tick();
      chk("t4_c_valid", deq_valid, 0);
      chk("t4_c_busy", busy, 1);
      drive(3'd1, 2'd0, 1'b0, 8'h02);
      tick();
      enq_valid = 1'b0;
      chk("t4_c_data", deq_bits_data, 32'h0000_0201);
      tick();
      chk("t4_drained", deq_valid, 0);

      // oversize message saturates at four beats
      deq_ready = 1'b0;
      drive(3'd3, 2'd2, 1'b0, 8'h01);
      tick();
      drive(3'd3, 2'd2, 1'b0, 8'h02);
      tick();
      drive(3'd3, 2'd2, 1'b0, 8'h03);
      tick();
      chk("t5_not_yet", deq_valid, 0);
      drive(3'd3, 2'd2, 1'b0, 8'h04);
      tick();
      enq_valid = 1'b0;
      chk("t5_valid", deq_valid, 1);
      chk("t5_size", deq_bits_size, 3);
      chk("t5_data", deq_bits_data, 32'h0403_0201);
      drive(3'd3, 2'd1, 1'b0, 8'hAA);
      deq_ready = 1'b1;
      tick();
      chk("t5_fifth_valid", deq_valid, 0);
      chk("t5_fifth_busy", busy, 1);

      // reset after two of four beats
      drive(3'd3, 2'd1, 1'b0, 8'hBB);
      tick();
      enq_valid = 1'b0;
      chk("t6_busy_pre", busy, 1);
      reset = 1'b1;
      #1;
      chk("t6_async_busy", busy, 0);
      tick();
      reset = 1'b0;
      chk("t6_rst_valid", deq_valid, 0);
      tick();
      chk("t6_no_spurious", deq_valid, 0);
      drive(3'd0, 2'd3, 1'b0, 8'h77);
      deq_ready = 1'b0;
      tick();
      enq_valid = 1'b0;
      chk("t6_valid", deq_valid, 1);
      chk("t6_data", deq_bits_data, 32'h0000_0077);
      chk("t6_error", deq_bits_error, 0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sirv_d_beat_gatherer.md
Name: sirv_d_beat_gatherer

Overview:
- Response-side counterpart of the A-channel byte repeater on the narrow TileLink peripheral path.
- A multi-byte request is split into single-byte beats going downstream. The peripheral then returns one D-channel beat per byte.
- This block gathers those 2^size byte responses into one full-width D response for the upstream master.
- Error flags are OR-accumulated across the beats.

Parameters:
- OUT_BYTES, 4, output data width in bytes; power of two, 2..8.
- SRC_W, 2, width of the source field.

Ports:
- clock  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- enq_ready  output  1  gatherer accepts an input beat
- enq_valid  input  1  input beat valid
- enq_bits_opcode  input  3  D opcode
- enq_bits_param  input  2  D param
- enq_bits_size  input  3  log2 of total message bytes
- enq_bits_source  input  SRC_W  source id
- enq_bits_error  input  1  beat error
- enq_bits_data  input  8  beat data byte
- deq_ready  input  1  upstream accepts the gathered response
- deq_valid  output  1  gathered response valid
- deq_bits_opcode  output  3  captured opcode
- deq_bits_param  output  2  captured param
- deq_bits_size  output  3  captured size
- deq_bits_source  output  SRC_W  captured source
- deq_bits_error  output  1  OR of all beat errors
- deq_bits_data  output  8*OUT_BYTES  gathered data
- busy  output  1  at least one beat of the current message has been accepted and the message is incomplete
- full  output  1  a gathered response is held (equals deq_valid)

Behaviour:
- State and counters:
  - Two-state FSM: COLLECT, FULL. Reset state is COLLECT.
  - Beat counter cnt is log2(OUT_BYTES) bits wide; reset value 0.
  - All deq_bits registers reset to 0. deq_valid=0, busy=0, full=0 at reset.
- Beat count per message:
  - beats = 1 << min(size, log2(OUT_BYTES)).
  - A size larger than log2(OUT_BYTES) saturates to OUT_BYTES beats; deq_bits_size still reports the original size.
- Handshake:
  - enq_ready = ~full | deq_ready. This is combinational and allows back-to-back messages.
  - An input beat fires on enq_valid & enq_ready.
  - deq fires on deq_valid & deq_ready.
- Size source for the last-beat check:
  - First beat (cnt==0): header fields are captured from the input beat, and enq_bits_size is used directly.
  - Later beats: the registered size is used. Header fields on later beats are ignored and not checked.
- Data placement:
  - Beat k writes byte lane k: data[8k+7:8k].
  - Lanes not written in the current message read 0. Lanes are cleared on acceptance of the first beat.
  - Data is captured for every opcode; an AccessAck beat carries whatever byte the peripheral drives.
- Error: cleared at the first beat, then error |= enq_bits_error on each beat.
- Last beat:
  - Condition: cnt == beats-1.
  - On acceptance: cnt returns to 0 and state goes to FULL. deq_valid rises on the next clock edge.
  - Latency is 1 cycle from the last enq fire to deq_valid.
- Non-last beat: cnt increments and busy=1.
- FULL state:
  - Outputs are stable until a deq fire.
  - deq fire with no enq fire in the same cycle: go to COLLECT.
  - deq fire and enq fire in the same cycle: the beat is the first beat of the next message and is processed as above.
    - If that message has beats==1, state stays FULL with the new data and deq_valid stays 1.
    - Otherwise, go to COLLECT with cnt=1.
- deq_valid never drops without a deq fire, except on reset.
- Reset mid-message: partial data is discarded. cnt=0, state COLLECT, no response is emitted for the partial message.
- No internal timeout. A missing beat stalls the block until reset.

Test Plan:
- Reset, then a single beat with size=0, data=0xA5, source=1, error=0.
  -> deq_valid=1 one cycle later; data=0x000000A5, source=1, size=0, error=0.
- size=2 with beats 0x11, 0x22, 0x33, 0x44 and enq_valid held high.
  -> busy=1 after the first beat; deq data=0x44332211 one cycle after the 4th beat; enq_ready=1 throughout while deq_ready=1.
- size=1 with beats 0xBE, 0xEF, error only on the 2nd beat, and deq_ready=0 for 5 cycles.
  -> deq data=0x0000EFBE and error=1 held stable; enq_ready=0 while FULL; response accepted when deq_ready rises.
- Back-to-back: FULL with message A while a size=0 beat 0x5A arrives and deq_ready=1.
  -> A is dequeued; B (data=0x0000005A) is valid the next cycle with no bubble.
- size=3 (saturate): 4 beats are accepted, then deq asserts with size=3.
  -> a fifth beat is treated as the first beat of a new message.
- Assert reset after 2 of 4 beats, then send a size=0 beat 0x77.
  -> the output is data=0x00000077 only; no stale bytes and no spurious deq_valid.
